j17_fetch_decode: RTL and testbench

- Fetch/decode control stage sitting directly upstream of the J17 datapath.
- Reads the datapath's PC and fetches a 32-bit instruction from instruction memory using a req/ack handshake.
- Decodes the instruction into the datapath control bundle (alucode, op1, op2, imControl, flag, regenable, ramenable, pcControl, writecode).
- Sequences the datapath with single-cycle commit strobes through a multi-cycle FSM.

---
 rtl/j17_pkg.sv | 37 +++
 rtl/j17_decoder.sv | 49 ++++
 rtl/j17_fetch_decode.sv | 127 ++++++++++++
 tb/tb_j17_fetch_decode.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/j17_pkg.sv
// Shared opcode map, FSM states and control-bundle layout for the J17 fetch/decode stage.
// Nothing in here holds state or adds latency.
package j17_pkg;

  localparam logic [4:0] OPC_NOP      = 5'h00;
  localparam logic [4:0] OPC_ALU_LAST = 5'h0B;
  localparam logic [4:0] OPC_LOAD     = 5'h10;
  localparam logic [4:0] OPC_STORE    = 5'h11;
  localparam logic [4:0] OPC_MOVI     = 5'h12;
  localparam logic [4:0] OPC_HALT     = 5'h17;
  localparam logic [4:0] OPC_BR_BASE  = 5'h18;

  localparam logic [1:0] RAM_IDLE = 2'b00;
  localparam logic [1:0] RAM_RD   = 2'b01;
  localparam logic [1:0] RAM_WR   = 2'b10;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_IMM = 2'd1;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, HALT} state_t;

  typedef struct packed {
    logic [4:0]  alucode;
    logic [4:0]  op1;
    logic [19:0] op2;
    logic        imcontrol;
    logic        flag;
    logic [2:0]  pccontrol;
    logic [1:0]  writecode;
    logic        wr_reg;
    logic        is_load;
    logic        is_store;
    logic        is_halt;
    logic        illegal;
  } ctrl_t;

endpackage

// File: rtl/j17_decoder.sv
// Combinational instruction-word to control-bundle decoder; zero latency.
// Unknown opcodes decode as NOP with the illegal flag raised.
module j17_decoder
  import j17_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [4:0] opc;
  logic       unused_bit;

  assign opc        = instr[31:27];
  assign unused_bit = instr[20];

  always_comb begin
    ctrl     = '0;
    ctrl.op1 = instr[26:22];
    ctrl.op2 = instr[19:0];
    if (opc >= 5'h01 && opc <= OPC_ALU_LAST) begin
      ctrl.alucode   = opc;
      ctrl.imcontrol = instr[21];
      ctrl.writecode = WB_ALU;
      ctrl.wr_reg    = 1'b1;
    end else if (opc >= OPC_BR_BASE) begin
      // 0x18 naturally yields condition 0, i.e. fall-through
      ctrl.pccontrol = opc[2:0];
    end else begin
      case (opc)
        OPC_NOP: ;
        OPC_LOAD: begin
          ctrl.imcontrol = 1'b1;
          ctrl.flag      = 1'b1;
          ctrl.writecode = WB_IMM;
          ctrl.is_load   = 1'b1;
        end
        OPC_STORE: ctrl.is_store = 1'b1;
        OPC_MOVI: begin
          ctrl.imcontrol = 1'b1;
          ctrl.writecode = WB_IMM;
          ctrl.wr_reg    = 1'b1;
        end
        OPC_HALT: ctrl.is_halt = 1'b1;
        default:  ctrl.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/j17_fetch_decode.sv
// J17 fetch/decode sequencer: 3 cycles per instruction (4 for LOAD) plus one per imem wait cycle.
// imem_req is held until imem_ack; a fetch that waits FETCH_TIMEOUT cycles faults and halts.
module j17_fetch_decode
  import j17_pkg::*;
#(
  parameter int IADDR_W       = 10,
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        pc,
  output logic               imem_req,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_data,
  output logic [4:0]         alucode,
  output logic [4:0]         op1,
  output logic [19:0]        op2,
  output logic               imControl,
  output logic               flag,
  output logic               regenable,
  output logic [1:0]         ramenable,
  output logic [2:0]         pcControl,
  output logic [1:0]         writecode,
  output logic               pc_step,
  output logic [31:0]        retired,
  output logic               halted,
  output logic               fault
);

  localparam int CW = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(FETCH_TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [31:0]   ir;
  logic [CW-1:0] cnt;
  ctrl_t         ctrl;
  logic          unused_pc;

  assign unused_pc = ^pc;

  // ir only changes on the accepting edge, so decoded outputs hold from DECODE to the next DECODE
  j17_decoder u_dec (
    .instr (ir),
    .ctrl  (ctrl)
  );

  assign alucode   = ctrl.alucode;
  assign op1       = ctrl.op1;
  assign op2       = ctrl.op2;
  assign imControl = ctrl.imcontrol;
  assign flag      = ctrl.flag;
  assign pcControl = ctrl.pccontrol;
  assign writecode = ctrl.writecode;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    imem_addr = '0;
    regenable = 1'b0;
    pc_step   = 1'b0;
    ramenable = RAM_IDLE;
    case (state)
      FETCH: begin
        // gated by reset so the request drops combinationally when reset asserts
        imem_req  = !reset;
        imem_addr = reset ? '0 : pc[IADDR_W-1:0];
        if (imem_ack)          state_nxt = DECODE;
        else if (cnt == TO_LAST) state_nxt = HALT;
      end
      DECODE: state_nxt = EXEC;
      EXEC: begin
        if (ctrl.is_load) begin
          ramenable = RAM_RD;
          state_nxt = MEM;
        end else if (ctrl.is_halt) begin
          state_nxt = HALT;
        end else begin
          regenable = ctrl.wr_reg;
          pc_step   = 1'b1;
          ramenable = ctrl.is_store ? RAM_WR : RAM_IDLE;
          state_nxt = FETCH;
        end
      end
      MEM: begin
        regenable = 1'b1;
        pc_step   = 1'b1;
        ramenable = RAM_RD;
        state_nxt = FETCH;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir      <= '0;
      cnt     <= '0;
      retired <= '0;
      halted  <= 1'b0;
      fault   <= 1'b0;
    end else begin
      if (state == FETCH) begin
        if (imem_ack) begin
          ir  <= imem_data;
          cnt <= '0;
        end else if (cnt == TO_LAST) begin
          fault  <= 1'b1;
          halted <= 1'b1;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
      if (pc_step)                      retired <= retired + 32'd1;
      if (state == EXEC && ctrl.illegal) fault  <= 1'b1;
      if (state == EXEC && ctrl.is_halt) halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_j17_fetch_decode.sv
// Randomized self-checking bench for j17_fetch_decode against an instruction-level reference model.
module tb_j17_fetch_decode;

  logic        clock;
  logic        reset;
  logic [31:0] pc;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [4:0]  alucode;
  logic [4:0]  op1;
  logic [19:0] op2;
  logic        imControl;
  logic        flag;
  logic        regenable;
  logic [1:0]  ramenable;
  logic [2:0]  pcControl;
  logic [1:0]  writecode;
  logic        pc_step;
  logic [31:0] retired;
  logic        halted;
  logic        fault;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_retired;
  logic        exp_fault;
  logic        exp_halted;

  j17_fetch_decode #(.IADDR_W(10), .FETCH_TIMEOUT(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .pc        (pc),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .alucode   (alucode),
    .op1       (op1),
    .op2       (op2),
    .imControl (imControl),
    .flag      (flag),
    .regenable (regenable),
    .ramenable (ramenable),
    .pcControl (pcControl),
    .writecode (writecode),
    .pc_step   (pc_step),
    .retired   (retired),
    .halted    (halted),
    .fault     (fault)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic apply_reset();
    reset    = 1'b1;
    imem_ack = 1'b0;
    repeat (2) @(negedge clock);
    reset       = 1'b0;
    exp_retired = '0;
    exp_fault   = 1'b0;
    exp_halted  = 1'b0;
    @(negedge clock);
  endtask

  // Runs one instruction through fetch/decode/execute; called at a negedge while the DUT is fetching.
  task automatic do_instr(input logic [31:0] instr, input int delay, input logic [31:0] pcv);
    logic [4:0]  opc;
    logic        alu, ld, st, mv, hl, br, legal;
    logic [36:0] exp_ctrl;
    logic [3:0]  exp_strb;
    opc   = instr[31:27];
    alu   = (opc >= 5'd1) && (opc <= 5'd11);
    ld    = (opc == 5'h10);
    st    = (opc == 5'h11);
    mv    = (opc == 5'h12);
    hl    = (opc == 5'h17);
    br    = (opc >= 5'h18);
    legal = (opc == 5'd0) | alu | ld | st | mv | hl | br;
    exp_ctrl = {alu ? opc : 5'd0, instr[26:22], instr[19:0],
                alu ? instr[21] : (ld | mv), ld, br ? opc[2:0] : 3'd0,
                (ld | mv) ? 2'd1 : 2'd0};
    pc = pcv;
    #1;
    for (int w = 0; w <= delay; w++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== pcv[9:0]) begin
        errors++;
        $display("FAIL fetch_req cycle %0d: req=%b addr=%h, expected req=1 addr=%h", w, imem_req, imem_addr, pcv[9:0]);
      end
      imem_ack  = (w == delay);
      imem_data = (w == delay) ? instr : $urandom;
      @(negedge clock);
    end
    imem_ack  = 1'b0;
    imem_data = $urandom;
    checks++;
    if ({alucode, op1, op2, imControl, flag, pcControl, writecode} !== exp_ctrl ||
        {regenable, pc_step, ramenable, imem_req} !== 5'b0) begin
      errors++;
      $display("FAIL decode instr=%h: ctrl=%h strobes=%b, expected ctrl=%h strobes=00000", instr,
               {alucode, op1, op2, imControl, flag, pcControl, writecode},
               {regenable, pc_step, ramenable, imem_req}, exp_ctrl);
    end
    @(negedge clock);
    exp_strb = {alu | mv, !ld && !hl, ld ? 2'b01 : (st ? 2'b10 : 2'b00)};
    checks++;
    if ({regenable, pc_step, ramenable} !== exp_strb ||
        {alucode, op1, op2, imControl, flag, pcControl, writecode} !== exp_ctrl) begin
      errors++;
      $display("FAIL exec instr=%h: strobes=%b ctrl=%h, expected strobes=%b ctrl=%h", instr,
               {regenable, pc_step, ramenable}, {alucode, op1, op2, imControl, flag, pcControl, writecode},
               exp_strb, exp_ctrl);
    end
    if (ld) begin
      @(negedge clock);
      checks++;
      if ({regenable, pc_step, ramenable} !== 4'b1101 ||
          {alucode, op1, op2, imControl, flag, pcControl, writecode} !== exp_ctrl) begin
        errors++;
        $display("FAIL mem instr=%h: strobes=%b ctrl=%h, expected strobes=1101 ctrl=%h", instr,
                 {regenable, pc_step, ramenable}, {alucode, op1, op2, imControl, flag, pcControl, writecode}, exp_ctrl);
      end
    end
    if (!hl)    exp_retired = exp_retired + 32'd1;
    if (!legal) exp_fault   = 1'b1;
    if (hl)     exp_halted  = 1'b1;
    @(negedge clock);
    checks++;
    if (retired !== exp_retired || fault !== exp_fault || halted !== exp_halted || imem_req !== !hl) begin
      errors++;
      $display("FAIL commit instr=%h: retired=%0d fault=%b halted=%b req=%b, expected %0d %b %b %b", instr,
               retired, fault, halted, imem_req, exp_retired, exp_fault, exp_halted, !hl);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    imem_ack  = 1'b1;
    imem_data = 32'hFFFF_FFFF;
    pc        = 32'h0000_0123;
    repeat (2) @(negedge clock);
    checks++;
    if ({imem_req, imem_addr, alucode, op1, op2, imControl, flag, regenable, ramenable,
         pcControl, writecode, pc_step, retired, halted, fault} !== '0) begin
      errors++;
      $display("FAIL reset_state: req=%b addr=%h retired=%0d halted=%b fault=%b, expected all zero",
               imem_req, imem_addr, retired, halted, fault);
    end
    imem_ack = 1'b0;
    reset    = 1'b0;
    exp_retired = '0;
    exp_fault   = 1'b0;
    exp_halted  = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_add_zero_wait();
    do_instr(32'h0840_0000, 0, 32'h0000_0004);
  endtask

  task automatic test_load_delayed();
    do_instr({5'h10, 5'd7, 2'b00, 20'h0ABCD}, 3, 32'h0000_0208);
  endtask

  task automatic test_branch();
    do_instr({5'h1B, 5'd2, 2'b11, 20'h0F00F}, 1, 32'h0000_0010);
    do_instr({5'h18, 5'd0, 2'b00, 20'h00001}, 0, 32'h0000_0014);
  endtask

  task automatic test_random();
    logic [4:0] opc;
    for (int i = 0; i < 40; i++) begin
      opc = 5'($urandom_range(0, 31));
      if (opc == 5'h17) opc = 5'h12;
      do_instr({opc, 27'($urandom)}, $urandom_range(0, 4), $urandom);
    end
  endtask

  task automatic test_illegal_then_halt();
    apply_reset();
    do_instr({5'h14, 27'h155_5555}, 0, 32'h0000_0040);
    do_instr({5'h17, 27'h0}, 2, 32'h0000_0044);
    imem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (imem_req !== 1'b0 || halted !== 1'b1 || fault !== 1'b1 || retired !== exp_retired || pc_step !== 1'b0) begin
        errors++;
        $display("FAIL halt_hold cycle %0d: req=%b halted=%b fault=%b retired=%0d step=%b, expected 0 1 1 %0d 0",
                 i, imem_req, halted, fault, retired, pc_step, exp_retired);
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_reset_midfetch();
    apply_reset();
    do_instr({5'h02, 5'd9, 2'b10, 20'h12345}, 0, 32'h0000_0100);
    pc = 32'h0000_0104;
    #1;
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL midfetch_req_before: req=%b, expected 1", imem_req);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({imem_req, imem_addr, alucode, op1, op2, imControl, flag, regenable, ramenable,
         pcControl, writecode, pc_step, retired, halted, fault} !== '0) begin
      errors++;
      $display("FAIL midfetch_reset: req=%b addr=%h alucode=%h op1=%h retired=%0d, expected all zero",
               imem_req, imem_addr, alucode, op1, retired);
    end
    @(negedge clock);
    reset = 1'b0;
    exp_retired = '0;
    exp_fault   = 1'b0;
    exp_halted  = 1'b0;
    do_instr({5'h12, 5'd3, 2'b00, 20'h00077}, 1, 32'h0000_0300);
  endtask

  task automatic test_timeout();
    reset    = 1'b1;
    imem_ack = 1'b0;
    pc       = 32'h0000_0050;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      checks++;
      if (imem_req !== 1'b1 || fault !== 1'b0 || halted !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait cycle %0d: req=%b fault=%b halted=%b, expected 1 0 0", i, imem_req, fault, halted);
      end
    end
    @(negedge clock);
    checks++;
    if (imem_req !== 1'b0 || fault !== 1'b1 || halted !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fault: req=%b fault=%b halted=%b, expected 0 1 1", imem_req, fault, halted);
    end
    imem_ack  = 1'b1;
    imem_data = 32'h0840_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (imem_req !== 1'b0 || retired !== 32'd0 || alucode !== 5'd0 || halted !== 1'b1 || pc_step !== 1'b0) begin
        errors++;
        $display("FAIL late_ack cycle %0d: req=%b retired=%0d alucode=%h halted=%b step=%b, expected 0 0 00 1 0",
                 i, imem_req, retired, alucode, halted, pc_step);
      end
    end
    imem_ack = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    pc          = '0;
    imem_ack    = 1'b0;
    imem_data   = '0;
    exp_retired = '0;
    exp_fault   = 1'b0;
    exp_halted  = 1'b0;
    test_reset();
    test_add_zero_wait();
    test_load_delayed();
    test_branch();
    test_random();
    test_illegal_then_halt();
    test_reset_midfetch();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
